// File: rtl/arb_req_sequencer.sv
// Client-side request sequencer for the two-input tree arbiter: queues jobs per
// client, runs a four-phase R/A handshake per channel and flags protocol faults.

module arb_req_channel #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int LEN_W       = 8,
  parameter int STARVE_LIM  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job,
  input  logic [LEN_W-1:0] len,
  input  logic             a,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pend,
  output logic             full,
  output logic             starve,
  output logic             gs,
  output logic             viol
);

  localparam int WAIT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, REL} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] a_sync_p;
  logic [CNT_W-1:0]       pend_q;
  logic [LEN_W-1:0]       hold_q, hold_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   starve_q, starve_set;
  logic                   r_q, done_q, deq, inc;

  function automatic logic [CNT_W-1:0] pend_update(input logic [CNT_W-1:0] cur,
                                                   input logic inc_i, input logic dec_i);
    case ({inc_i, dec_i})
      2'b10:   return cur + CNT_W'(1);
      2'b01:   return cur - CNT_W'(1);
      default: return cur;
    endcase
  endfunction

  // Zero-length jobs still hold the resource for one cycle.
  function automatic logic [LEN_W-1:0] hold_load(input logic [LEN_W-1:0] l);
    return (l == '0) ? '0 : l - LEN_W'(1);
  endfunction

  assign gs   = a_sync_p[SYNC_STAGES-1];
  assign full = (pend_q == '1);
  assign inc  = job && !full;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    starve_set = 1'b0;
    deq        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = REQ;
          deq     = 1'b1;
          wait_d  = '0;
        end
      end
      REQ: begin
        if (gs) begin
          state_d = BUSY;
          hold_d  = hold_load(len);
        end else if (wait_q == WAIT_LIM) begin
          starve_set = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      BUSY: begin
        if (hold_q == '0) state_d = REL;
        else              hold_d  = hold_q - LEN_W'(1);
      end
      REL: begin
        if (!gs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // R and done are flopped from the next-state decode so the arbiter sees a glitch-free request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_p <= '0;
      state_q  <= IDLE;
      pend_q   <= '0;
      hold_q   <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sync_p <= {a_sync_p[SYNC_STAGES-2:0], a};
      state_q  <= state_d;
      pend_q   <= pend_update(pend_q, inc, deq);
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      starve_q <= starve_q | starve_set;
      r_q      <= (state_d == REQ) || (state_d == BUSY);
      done_q   <= (state_q == BUSY) && (state_d == REL);
    end
  end

  // A grant may only be seen high between REQ and REL, and must stay high through BUSY.
  assign viol   = ((state_q == BUSY) && !gs) || ((state_q == IDLE) && gs);
  assign r      = r_q;
  assign busy   = (state_q == BUSY);
  assign done   = done_q;
  assign pend   = pend_q;
  assign starve = starve_q;

endmodule

module arb_req_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int LEN_W       = 8,
  parameter int STARVE_LIM  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job1,
  input  logic [LEN_W-1:0] len1,
  input  logic             job2,
  input  logic [LEN_W-1:0] len2,
  input  logic             A1,
  input  logic             A2,
  output logic             R1,
  output logic             R2,
  output logic             busy1,
  output logic             busy2,
  output logic             done1,
  output logic             done2,
  output logic [CNT_W-1:0] pend1,
  output logic [CNT_W-1:0] pend2,
  output logic             full1,
  output logic             full2,
  output logic             starve1,
  output logic             starve2,
  output logic             proto_err
);

  logic gs1, gs2, viol1, viol2, proto_q;

  arb_req_channel #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .LEN_W(LEN_W), .STARVE_LIM(STARVE_LIM)
  ) u_ch1 (
    .clk(clk), .rst_n(rst_n), .job(job1), .len(len1), .a(A1),
    .r(R1), .busy(busy1), .done(done1), .pend(pend1), .full(full1),
    .starve(starve1), .gs(gs1), .viol(viol1)
  );

  arb_req_channel #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .LEN_W(LEN_W), .STARVE_LIM(STARVE_LIM)
  ) u_ch2 (
    .clk(clk), .rst_n(rst_n), .job(job2), .len(len2), .a(A2),
    .r(R2), .busy(busy2), .done(done2), .pend(pend2), .full(full2),
    .starve(starve2), .gs(gs2), .viol(viol2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_q <= 1'b0;
    else        proto_q <= proto_q | (gs1 & gs2) | viol1 | viol2;
  end

  assign proto_err = proto_q;

endmodule

// File: doc/arb_req_sequencer.md
Name: arb_req_sequencer

Overview:
- Upstream client-side stage for the two-input cascoded tree arbiter.
- Queues job tokens per client and drives requests R1/R2 to the arbiter using a four-phase handshake.
- Synchronises the arbiter's grants A1/A2, which are asynchronous, combinational outputs, into the clock domain.
- Holds each granted resource for a programmed number of cycles, then releases it and reports completion and protocol errors.

Parameters:
- SYNC_STAGES, 2: flop stages on each grant input; minimum 2.
- CNT_W, 4: width of each per-client pending-job counter; maximum count is 2^CNT_W-1.
- LEN_W, 8: width of the hold-length inputs.
- STARVE_LIM, 255: cycles in REQ without a grant before the starve flag sets.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- job1  in  1  one-cycle pulse; enqueues one job for client 1.
- len1  in  LEN_W  hold cycles for client 1; sampled on entry to BUSY.
- job2  in  1  as job1, for client 2.
- len2  in  LEN_W  as len1, for client 2.
- A1  in  1  arbiter grant 1; asynchronous to clk.
- A2  in  1  arbiter grant 2; asynchronous to clk.
- R1  out  1  request 1 to the arbiter; registered.
- R2  out  1  request 2 to the arbiter; registered.
- busy1, busy2  out  1  client currently owns the resource.
- done1, done2  out  1  one-cycle job-complete pulse.
- pend1, pend2  out  CNT_W  jobs queued and not yet started.
- full1, full2  out  1  pendN equals 2^CNT_W-1.
- starve1, starve2  out  1  sticky; REQ wait exceeded STARVE_LIM.
- proto_err  out  1  sticky handshake-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 immediately.
  - FSMs go to IDLE; counters, sync flops and sticky flags clear.
  - A reset mid-BUSY drops R immediately; the in-flight job is lost and no done pulse is produced.
- Grant synchronisation: gsN is AN after SYNC_STAGES flops. All FSM decisions use gsN only, never raw AN.
- Pending counter, per client:
  - Increments on jobN when not full.
  - Decrements on the IDLE->REQ transition.
  - Simultaneous increment and decrement leaves the count unchanged.
  - jobN while full is dropped silently.
  - No wrap-around in either direction.
- FSM per client; the two channels are independent and identical.
  - IDLE: R=0. If pend>0, go to REQ next cycle and dequeue; R rises on that edge.
  - REQ: R=1, wait counter runs.
    - gs=1: go to BUSY; load hold counter with max(len,1)-1; busy=1.
    - Wait counter reaches STARVE_LIM: set starve (sticky) and keep waiting.
  - BUSY: R=1, busy=1; hold counter decrements each cycle.
    - Counter at 0: go to REL; R drops and done pulses on the REL-entry edge.
    - busy lasts exactly max(len,1) cycles.
  - REL: R=0, busy=0. Wait for gs=0, then go to IDLE.
    - The next job may enter REQ on the cycle after IDLE is reached.
- Latency:
  - job pulse to R high: 2 cycles (counter update, then IDLE->REQ edge).
  - A high to busy high: SYNC_STAGES+1 cycles.
- proto_err sets (sticky, cleared only by reset) when any of these holds:
  - gs1 and gs2 are both 1 in the same cycle (mutual-exclusion failure).
  - gs falls while in BUSY. The FSM still completes BUSY normally.
  - gs rises while in IDLE.
- Grants that glitch narrower than one clock may be missed. This is acceptable: the FSM stays in REQ.

Test Plan:
1. Reset, then a job1 pulse with len1=3, arbiter model granting on request → R1 rises 2 cycles after job1; busy1 high for exactly 3 cycles; done1 pulses once; R1 low; FSM back in IDLE after A1 falls; pend1 goes 1→0.
2. job1 and job2 pulsed in the same cycle, tree arbiter resolving with A1 first (both requests high, as in the arbiter's own test sequence) → client 1 completes, R1 drops, A2 follows; busy1 and busy2 never overlap; proto_err stays 0.
3. 16 job1 pulses with CNT_W=4 and A1 held low → pend1 saturates at 15, full1=1; starve1 sets after 255 REQ cycles; R1 stays high.
4. len1=0 → busy1 high for 1 cycle; done1 pulses.
5. Force A1 and A2 both high for 3 cycles → proto_err=1 after SYNC_STAGES+1 cycles; it stays set until rst_n is pulsed low.
6. Assert rst_n low during BUSY with len1=200 → R1 and busy1 go to 0 asynchronously; no done1 pulse; pend1=0 after reset.
